// File: rtl/toy_bpu_btb_bank_if.sv
// Lookup, update, flush and status signals of the BTB storage bank.
// The BPU side drives through master; the bank itself uses slave.
interface toy_bpu_btb_bank_if #(
    parameter int WAY_NUM    = 4,
    parameter int SET_NUM    = 64,
    parameter int TAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 40
);
    localparam int IDX_W = $clog2(SET_NUM);

    logic                  flush;
    logic                  req_vld;
    logic                  req_rdy;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  ack_vld;
    logic                  ack_hit;
    logic [WAY_NUM-1:0]    ack_way;
    logic [DATA_WIDTH-1:0] ack_data;
    logic                  upd_vld;
    logic                  upd_rdy;
    logic [IDX_W-1:0]      upd_idx;
    logic [TAG_WIDTH-1:0]  upd_tag;
    logic [DATA_WIDTH-1:0] upd_data;
    logic                  upd_inv;
    logic                  busy;

    modport master (
        output flush, req_vld, req_idx, req_tag,
        output upd_vld, upd_idx, upd_tag, upd_data, upd_inv,
        input  req_rdy, ack_vld, ack_hit, ack_way, ack_data, upd_rdy, busy
    );

    modport slave (
        input  flush, req_vld, req_idx, req_tag,
        input  upd_vld, upd_idx, upd_tag, upd_data, upd_inv,
        output req_rdy, ack_vld, ack_hit, ack_way, ack_data, upd_rdy, busy
    );
endinterface

// File: rtl/toy_bpu_btb_bank.sv
// Set-associative BTB storage bank: 1-cycle lookup, allocate-on-miss update,
// tree-PLRU replacement and a one-set-per-cycle invalidate sweep.
module toy_bpu_btb_bank #(
    parameter int WAY_NUM    = 4,
    parameter int SET_NUM    = 64,
    parameter int TAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 40
) (
    input  logic clk,
    input  logic rst,
    toy_bpu_btb_bank_if.slave bus
);
    localparam int IDX_W    = $clog2(SET_NUM);
    localparam int WAY_W    = $clog2(WAY_NUM);
    localparam int NODE_NUM = WAY_NUM - 1;

    typedef enum logic {ST_FLUSH, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [WAY_NUM-1:0]    valid_q [SET_NUM];
    logic [NODE_NUM-1:0]   plru_q  [SET_NUM];
    logic [TAG_WIDTH-1:0]  tag_q   [SET_NUM][WAY_NUM];
    logic [DATA_WIDTH-1:0] data_q  [SET_NUM][WAY_NUM];

    logic                  ack_vld_q, ack_hit_q;
    logic [WAY_NUM-1:0]    ack_way_q;
    logic [DATA_WIDTH-1:0] ack_data_q;

    logic                  req_acc, upd_acc;
    logic                  lk_hit, lk_touch;
    logic [WAY_W-1:0]      lk_way;
    logic [WAY_NUM-1:0]    lk_oh;
    logic [DATA_WIDTH-1:0] lk_data;
    logic                  up_hit, inv_found;
    logic [WAY_W-1:0]      up_hit_way, inv_way, plru_vic, tgt_way;

    // Heap-ordered node walk: bit 0 descends left, bit 1 descends right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODE_NUM-1:0] nodes);
        int n;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            n = 2 * n + 1 + int'(nodes[n]);
        end
        return WAY_W'(n - NODE_NUM);
    endfunction

    function automatic logic [NODE_NUM-1:0] plru_touch(input logic [NODE_NUM-1:0] nodes,
                                                       input logic [WAY_W-1:0] way);
        logic [NODE_NUM-1:0] res;
        int n, p;
        res = nodes;
        n   = int'(way) + NODE_NUM;
        for (int l = 0; l < WAY_W; l++) begin
            p      = (n - 1) / 2;
            res[p] = (n % 2 == 1);
            n      = p;
        end
        return res;
    endfunction

    assign bus.req_rdy  = (state_q == ST_RUN);
    assign bus.upd_rdy  = (state_q == ST_RUN);
    assign bus.busy     = (state_q == ST_FLUSH);
    assign bus.ack_vld  = ack_vld_q;
    assign bus.ack_hit  = ack_hit_q;
    assign bus.ack_way  = ack_way_q;
    assign bus.ack_data = ack_data_q;

    assign req_acc = bus.req_vld && bus.req_rdy;
    assign upd_acc = bus.upd_vld && bus.upd_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_FLUSH) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(SET_NUM - 1)) begin
                state_d = ST_RUN;
            end
        end
        if (bus.flush) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lowest matching way wins should the tag array ever hold duplicates.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        lk_oh   = '0;
        lk_data = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (!lk_hit && valid_q[bus.req_idx][w] && tag_q[bus.req_idx][w] == bus.req_tag) begin
                lk_hit  = 1'b1;
                lk_way  = WAY_W'(w);
                lk_oh[w] = 1'b1;
                lk_data = data_q[bus.req_idx][w];
            end
        end
    end

    always_comb begin
        up_hit     = 1'b0;
        up_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (!up_hit && valid_q[bus.upd_idx][w] && tag_q[bus.upd_idx][w] == bus.upd_tag) begin
                up_hit     = 1'b1;
                up_hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[bus.upd_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        plru_vic = plru_victim(plru_q[bus.upd_idx]);
        tgt_way  = up_hit ? up_hit_way : (inv_found ? inv_way : plru_vic);
        lk_touch = req_acc && lk_hit &&
                   !(upd_acc && !bus.upd_inv && bus.upd_idx == bus.req_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_vld_q  <= 1'b0;
            ack_hit_q  <= 1'b0;
            ack_way_q  <= '0;
            ack_data_q <= '0;
        end else begin
            ack_vld_q  <= req_acc;
            ack_hit_q  <= req_acc && lk_hit;
            ack_way_q  <= req_acc ? lk_oh : '0;
            ack_data_q <= req_acc ? lk_data : '0;
        end
    end

    // Storage is not reset; reset and flush both route through the sweep,
    // and any request colliding with a flush pulse leaves storage untouched.
    always_ff @(posedge clk) begin
        if (state_q == ST_FLUSH) begin
            valid_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
        end else if (!rst && !bus.flush) begin
            if (lk_touch) begin
                plru_q[bus.req_idx] <= plru_touch(plru_q[bus.req_idx], lk_way);
            end
            if (upd_acc && bus.upd_inv && up_hit) begin
                valid_q[bus.upd_idx][up_hit_way] <= 1'b0;
            end
            if (upd_acc && !bus.upd_inv) begin
                tag_q[bus.upd_idx][tgt_way]   <= bus.upd_tag;
                data_q[bus.upd_idx][tgt_way]  <= bus.upd_data;
                valid_q[bus.upd_idx][tgt_way] <= 1'b1;
                plru_q[bus.upd_idx]           <= plru_touch(plru_q[bus.upd_idx], tgt_way);
            end
        end
    end
endmodule
